// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC request scheduler.
package cordic_pkg;
   localparam int NREQ       = 4;
   localparam int ANGLE_W    = 32;
   localparam int PIPE_DEPTH = 16;
   localparam int ID_W       = $clog2(NREQ);

   localparam logic [ANGLE_W-1:0] ANG_P90 = 32'h4000_0000;
   localparam logic [ANGLE_W-1:0] ANG_N90 = 32'hC000_0000;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;
endpackage

// File: rtl/cordic_sched_fifo.sv
// Synchronous FIFO whose head entry sits in its own register, so pushes
// become visible one cycle later and the outputs reset to zero.
module cordic_sched_fifo #(
   parameter int DEPTH  = 32,
   parameter int DATA_W = 34
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [DATA_W-1:0]          wdata,
   input  logic                       pop,
   output logic [DATA_W-1:0]          rdata,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d, remain_s;
   logic [DATA_W-1:0] head_q, head_d;
   logic              do_push_s, do_pop_s;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      if (p == AW'(DEPTH - 1)) begin
         return '0;
      end else begin
         return p + AW'(1);
      end
   endfunction

   // Next-state: pointers, occupancy and the value the head register must hold.
   always_comb begin
      do_pop_s  = pop && (count_q != '0);
      do_push_s = push && ((count_q != CW'(DEPTH)) || do_pop_s);
      wr_ptr_d  = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d  = do_pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      remain_s  = count_q - CW'(do_pop_s);
      count_d   = remain_s + CW'(do_push_s);
      if (count_d == '0) begin
         head_d = '0;
      end else if (remain_s == '0) begin
         head_d = wdata;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Pointer, count and head registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   assign rdata = head_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
endmodule

// File: rtl/cordic_req_scheduler.sv
// Round-robin scheduler feeding a shared pipelined CORDIC; tags each slot and
// collects results into a credit-protected response FIFO.
module cordic_req_scheduler
   import cordic_pkg::*;
#(
   parameter int FIFO_DEPTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*ANGLE_W-1:0] req_angle,
   output logic [NREQ-1:0]         req_ready,
   output logic [ANGLE_W-1:0]      cordic_g,
   input  logic [ANGLE_W-1:0]      cordic_z,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [ANGLE_W-1:0]      rsp_data
);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int DATA_W = ID_W + ANGLE_W;

   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ANGLE_W-1:0] cordic_g_q, cordic_g_d;
   tag_t               tag_in_q, tag_in_d;
   tag_t               tag_q [PIPE_DEPTH];
   logic               gnt_found_s, issue_s, pop_s;
   logic [ID_W-1:0]    gnt_id_s;
   logic [NREQ-1:0]    req_ready_s;
   logic [DATA_W-1:0]  fifo_rdata_s;
   logic               fifo_empty_s, fifo_full_s;
   logic [CNT_W-1:0]   fifo_count_s;
   logic [CNT_W:0]     fifo_unused_s;

   // Round-robin search from ptr; blocked while reset or out of credit.
   always_comb begin
      logic [ID_W-1:0] idx;
      gnt_found_s = 1'b0;
      gnt_id_s    = '0;
      idx         = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = ID_W'((int'(ptr_q) + k) % NREQ);
         if (!gnt_found_s && req_valid[idx]) begin
            gnt_found_s = 1'b1;
            gnt_id_s    = idx;
         end else begin
            gnt_found_s = gnt_found_s;
         end
      end
      issue_s     = reset && (cnt_q < CNT_W'(FIFO_DEPTH)) && gnt_found_s;
      req_ready_s = '0;
      if (issue_s) begin
         req_ready_s[gnt_id_s] = 1'b1;
      end else begin
         req_ready_s = '0;
      end
   end

   // Issue path, pointer advance and credit accounting.
   always_comb begin
      ptr_d      = ptr_q;
      cordic_g_d = '0;
      tag_in_d   = '0;
      if (issue_s) begin
         ptr_d          = (gnt_id_s == ID_W'(NREQ - 1)) ? '0 : gnt_id_s + ID_W'(1);
         cordic_g_d     = req_angle[gnt_id_s*ANGLE_W +: ANGLE_W];
         tag_in_d.valid = 1'b1;
         tag_in_d.id    = gnt_id_s;
      end else begin
         ptr_d = ptr_q;
      end
      case ({issue_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // tag_in_q travels with cordic_g; tag_q[PIPE_DEPTH-1] lines up with cordic_z.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q      <= '0;
         cnt_q      <= '0;
         cordic_g_q <= '0;
         tag_in_q   <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         cordic_g_q <= cordic_g_d;
         tag_in_q   <= tag_in_d;
         tag_q[0]   <= tag_in_q;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   cordic_sched_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tag_q[PIPE_DEPTH-1].valid),
      .wdata ({tag_q[PIPE_DEPTH-1].id, cordic_z}),
      .pop   (pop_s),
      .rdata (fifo_rdata_s),
      .empty (fifo_empty_s),
      .full  (fifo_full_s),
      .count (fifo_count_s)
   );

   assign fifo_unused_s = {fifo_full_s, fifo_count_s};
   assign pop_s         = rsp_valid && rsp_ready;
   assign req_ready     = req_ready_s;
   assign cordic_g      = cordic_g_q;
   assign rsp_valid     = !fifo_empty_s;
   assign rsp_id        = fifo_rdata_s[ANGLE_W +: ID_W];
   assign rsp_data      = fifo_rdata_s[ANGLE_W-1:0];
endmodule

// File: tb/tb_cordic_req_scheduler.sv
// Directed and random stimulus against a transaction-level model of the scheduler.
module tb_cordic_req_scheduler;
   import cordic_pkg::*;

   localparam int NR = NREQ;
   localparam int AW = ANGLE_W;
   localparam int PD = PIPE_DEPTH;
   localparam int FD = 32;
   localparam logic [31:0] ZK = 32'h5A5A_5A5A;

   logic             clk = 1'b0;
   logic             reset;
   logic [NR-1:0]    req_valid;
   logic [NR*AW-1:0] req_angle;
   logic [NR-1:0]    req_ready;
   logic [AW-1:0]    cordic_g, cordic_z;
   logic             rsp_valid, rsp_ready;
   logic [ID_W-1:0]  rsp_id;
   logic [AW-1:0]    rsp_data;

   cordic_req_scheduler #(.FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_angle(req_angle),
      .req_ready(req_ready), .cordic_g(cordic_g), .cordic_z(cordic_z),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
   );

   always #5 clk = ~clk;

   // CORDIC stand-in: PD-cycle delay of g ^ ZK, never reset.
   logic [AW-1:0] zl [PD];
   always @(posedge clk) begin
      zl[0] <= cordic_g ^ ZK;
      for (int i = 1; i < PD; i++) zl[i] <= zl[i-1];
   end
   assign cordic_z = zl[PD-1];

   typedef struct {
      int            id;
      logic [AW-1:0] data;
      int            avail;
   } rsp_t;

   rsp_t          q[$];
   int            m_ptr, m_cnt, cyc;
   logic [AW-1:0] m_g;
   logic [NR-1:0] pend, cont;
   logic [AW-1:0] ang [NR];
   int            total, bad, ngr, npop, n1, first_v, hs;
   logic [AW-1:0] sweep [14] = '{32'hC000_0000, 32'hC22E_D8B2, 32'hC8A3_A7B0, 32'hD2BE_6034,
                                 32'hE000_0001, 32'hEF70_7A3F, 32'h0000_0000, 32'h1090_9FC2,
                                 32'h2000_0000, 32'h2D41_BACD, 32'h376C_4FD1, 32'h3DD1_3B8F,
                                 32'h4000_0000, 32'h0000_0001};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   function automatic int model_grant();
      if (m_cnt >= FD) return -1;
      for (int k = 0; k < NR; k++) begin
         if (pend[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
      end
      return -1;
   endfunction

   task automatic model_reset();
      q.delete();
      m_ptr = 0;
      m_cnt = 0;
      m_g   = '0;
      pend  = '0;
      cont  = '0;
   endtask

   task automatic tick();
      int            g;
      logic [NR-1:0] exp_rdy;
      logic          exp_v;
      rsp_t          e;
      req_valid = pend;
      for (int i = 0; i < NR; i++) req_angle[i*AW +: AW] = ang[i];
      @(negedge clk);
      g = model_grant();
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      exp_v = (q.size() > 0) && (q[0].avail <= cyc);
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("cordic_g", 64'(cordic_g), 64'(m_g));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
      if (exp_v) begin
         chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
         chk("rsp_data", 64'(rsp_data), 64'(q[0].data));
      end
      if (|req_ready) ngr++;
      if (rsp_valid && first_v < 0) first_v = cyc;
      if (rsp_valid && rsp_ready) begin
         npop++;
         if (rsp_id == ID_W'(1)) n1++;
      end
      if (g >= 0) begin
         e.id = g; e.data = ang[g] ^ ZK; e.avail = cyc + PD + 2;
         q.push_back(e);
         m_ptr = (g + 1) % NR;
         m_cnt++;
         m_g = ang[g];
         if (cont[g]) ang[g] = $urandom;
         else pend[g] = 1'b0;
      end else begin
         m_g = '0;
      end
      if (exp_v && rsp_ready) begin
         void'(q.pop_front());
         m_cnt--;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0; ngr = 0; npop = 0; n1 = 0; first_v = -1;
      for (int i = 0; i < NR; i++) ang[i] = '0;
      model_reset();
      reset = 1'b0; rsp_ready = 1'b0; req_valid = '0; req_angle = '0;
      #2;
      req_valid = '1;
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_cordic_g", 64'(cordic_g), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      req_valid = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;

      // 1: single request on requester 2
      rsp_ready = 1'b1; pend[2] = 1'b1; ang[2] = 32'h4000_0000;
      ngr = 0; first_v = -1; hs = cyc;
      repeat (25) tick();
      chk("t1_latency", 64'(first_v - hs), 64'(18));
      chk("t1_grants", 64'(ngr), 64'(1));

      // 2: all requesters continuously valid
      pend = '1; cont = '1;
      for (int i = 0; i < NR; i++) ang[i] = $urandom;
      repeat (40) tick();
      pend = '0; cont = '0;
      repeat (PD + 8) tick();

      // 3/4: backpressure until credits run out, then release and keep issuing
      rsp_ready = 1'b0; pend = '1; cont = '1; ngr = 0;
      repeat (50) tick();
      chk("t3_grants", 64'(ngr), 64'(32));
      rsp_ready = 1'b1; npop = 0;
      repeat (60) tick();
      pend = '0; cont = '0;
      repeat (PD + 40) tick();
      chk("t3_pops", 64'(npop), 64'(ngr));

      // 5: reset with 3 buffered and 10 in flight
      rsp_ready = 1'b0; pend = 4'b0111;
      repeat (11) tick();
      pend = '1; cont = '1;
      repeat (10) tick();
      reset = 1'b0; req_valid = '1;
      #1;
      chk("t5_req_ready", 64'(req_ready), 64'd0);
      chk("t5_cordic_g", 64'(cordic_g), 64'd0);
      chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("t5_rsp_id", 64'(rsp_id), 64'd0);
      chk("t5_rsp_data", 64'(rsp_data), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("t5_hold_ready", 64'(req_ready), 64'd0);
      model_reset();
      reset = 1'b1; rsp_ready = 1'b1; first_v = -1;
      repeat (2 * PD) tick();
      chk("t5_quiet", 64'(first_v), 64'(-1));

      // 6: angle sweep on requester 1
      n1 = 0;
      for (int s = 0; s < 14; s++) begin
         pend[1] = 1'b1; ang[1] = sweep[s];
         for (int n = 0; n < 10 && pend[1]; n++) tick();
      end
      repeat (PD + 8) tick();
      chk("t6_count", 64'(n1), 64'(14));

      // random traffic with random backpressure
      for (int r = 0; r < 400; r++) begin
         for (int i = 0; i < NR; i++) begin
            if (!pend[i]) begin
               ang[i] = $urandom;
               if ($urandom_range(0, 2) == 0) pend[i] = 1'b1;
            end
            cont[i] = ($urandom_range(0, 3) == 0);
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      pend = '0; cont = '0; rsp_ready = 1'b1;
      repeat (PD + FD + 10) tick();
      @(negedge clk);
      chk("final_empty", 64'(rsp_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
